disk_track_sequencer: RTL and testbench
=======================================

// Module: disk_track_sequencer
// PURPOSE
//  Sequences the SD block device for both Disk II drives: loads a 6656-byte track image
//  (13 x 512 B blocks) into the selected drive's track RAM whenever that drive's head lands
//  on an unloaded track. Writes the track back first when the drive has modified it.
//  Arbitrates the single SD channel between drive 1 and drive 2 and drives TRACKn_BUSY.
// PARAMETERS
//  BLOCKS_PER_TRACK  13  512-byte blocks per track; LBA = track*BLOCKS_PER_TRACK + blk
//  LBA_W             32  width of SD_LBA
// PORTS
//  CLK_14M        in   1   sole clock
//  RESET          in   1   synchronous, active-high reset
//  IMG_MOUNTED    in   2   1-cycle pulse per drive: new image mounted
//  DISK_READY     out  2   drive has a mounted image
//  TRACK1/TRACK2  in   6   current head track per drive
//  TRACK1_WE/TRACK2_WE in 1 drive wrote a byte into its track RAM (marks dirty)
//  D1_ACTIVE/D2_ACTIVE in 1 drive motor active
//  TRACK1_BUSY/TRACK2_BUSY out 1 track RAM not valid for current TRACKn, or transfer in progress
//  SD_LBA         out  LBA_W block address
//  SD_RD / SD_WR  out  2   per-drive read / write request
//  SD_ACK         in   2   per-drive acknowledge, high for the whole block transfer
//  SD_BUFF_ADDR   in   9   byte index within current block
//  SD_BUFF_WR     in   1   SD byte write strobe (read direction)
//  RAM_SEL        out  1   track RAM owned by transfer: 0 = drive 1, 1 = drive 2
//  RAM_ADDR       out  13  {blk[3:0], SD_BUFF_ADDR}, combinational
//  RAM_WE         out  1   SD_BUFF_WR gated by read transfer active, combinational
// BEHAVIOUR
//  Reset: all outputs 0; per-drive mounted/valid/dirty = 0; rr pointer = drive 2 (drive 1 first).
//  Per drive: cur_trk[5:0], valid, dirty, mounted. IMG_MOUNTED[n]: mounted=1, valid=0, dirty=0.
//  Need_load[n] = mounted & (!valid | cur_trk != TRACKn). Need_wb[n] = dirty & (need_load | D falling).
//  TRACKn_BUSY registered: = need_load[n] | (transfer owner==n); 1 cycle after TRACK change.
//  FSM: IDLE -> WB_REQ -> WB_ACK -> WB_DONE -> (next blk | RD_REQ) -> RD_ACK -> RD_DONE -> (next blk | FIN) -> IDLE.
//  IDLE: pick drive with need_wb|need_load; both pending -> one not last served; update rr.
//   Capture load track = TRACKn at grant; write-back uses old cur_trk. blk = 0.
//  *_REQ: SD_LBA valid, SD_RD[n]/SD_WR[n] = 1 held until SD_ACK[n] seen high; drop next cycle.
//  *_DONE: wait SD_ACK[n] low; blk==BLOCKS_PER_TRACK-1 ends phase, else blk+1, back to *_REQ.
//  WB end: dirty=0, then load phase only if need_load; else IDLE. RD end (FIN): cur_trk=captured,
//   valid=1; if TRACKn moved meanwhile, need_load re-triggers on next IDLE.
//  TRACKn_WE while TRACKn_BUSY ignored; otherwise sets dirty. Never set dirty on unmounted drive.
//  IMG_MOUNTED[n] during transfer for n: set abort; finish current block handshake (never
//   drop REQ before ACK), then IDLE with valid=0, dirty=0. Other drive's transfer unaffected.
//  RESET mid-transfer: immediate return to IDLE, all requests deasserted next cycle.
//  blk is 4 bits; LBA arithmetic unsigned, zero-extended to LBA_W (max 63*13+12 = 831).
// CONFIGURATION
//  DISK_WRITEBACK_EN defined: dirty tracking and WB states as above.
//  Undefined: dirty stuck 0, SD_WR always 0, WB states unreachable; TRACKn_WE ignored.
// STRUCTURE
//  Package disk_ii_pkg: BLOCKS_PER_TRACK, TRACK_BYTES=6656, BLK_BYTES=512, FSM state encodings.
//  Sub-module sd_block_xfer: one-block REQ/ACK handshake (start, is_write -> RD/WR, done pulse).
// TESTING
//  Mount drive 1, TRACK1=0 -> SD_RD[0] LBA 0..12 in order, 6656 RAM_WE, BUSY1 falls after blk 12.
//  Loaded drive 1 trk 0, one TRACK1_WE, TRACK1=3 -> SD_WR LBA 0..12, then SD_RD LBA 39..51.
//  Both drives need load same cycle after reset -> drive 1 served fully first, then drive 2.
//  IMG_MOUNTED[0] at blk 5 of load -> blk 5 handshake completes, no blk 6, valid stays 0, reload.
//  Dirty drive 2, D2_ACTIVE 1->0, track unchanged -> SD_WR LBA cur*13..+12, no read follows.
//  Without DISK_WRITEBACK_EN, TRACK1_WE then track change -> no SD_WR, read only.

Source files
------------

// File: rtl/disk_ii_pkg.sv
// Shared constants, FSM encodings and LBA helper for the Disk II track sequencer.
package disk_ii_pkg;

  localparam int unsigned BLOCKS_PER_TRACK = 13;
  localparam int unsigned BLK_BYTES        = 512;
  localparam int unsigned TRACK_BYTES      = BLOCKS_PER_TRACK * BLK_BYTES;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbAck,
    StWbDone,
    StRdReq,
    StRdAck,
    StRdDone,
    StFin
  } seq_state_e;

  typedef enum logic [1:0] {
    XIdle,
    XReq,
    XBusy
  } xfer_state_e;

  function automatic logic [31:0] lba_of(logic [5:0] trk, logic [3:0] blk, int unsigned bpt);
    return 32'(trk) * bpt + 32'(blk);
  endfunction

endpackage

// File: rtl/sd_block_xfer.sv
// One-block SD REQ/ACK handshake: request held until ACK high, done pulse once ACK falls.
module sd_block_xfer (
  input  logic       CLK_14M,
  input  logic       RESET,
  input  logic       start,
  input  logic       is_write,
  input  logic       drive,
  input  logic [1:0] SD_ACK,
  output logic [1:0] SD_RD,
  output logic [1:0] SD_WR,
  output logic       ack_seen,
  output logic       done
);
  import disk_ii_pkg::*;

  xfer_state_e state_q, state_d;
  logic        write_q;
  logic        drive_q;
  logic        ack;
  logic [1:0]  drv_onehot;

  assign ack        = SD_ACK[drive_q];
  assign drv_onehot = drive_q ? 2'b10 : 2'b01;
  assign SD_RD      = (state_q == XReq && !write_q) ? drv_onehot : 2'b00;
  assign SD_WR      = (state_q == XReq &&  write_q) ? drv_onehot : 2'b00;

  always_comb begin
    state_d  = state_q;
    ack_seen = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      XIdle: if (start) state_d = XReq;
      XReq: begin
        if (ack) begin
          ack_seen = 1'b1;
          state_d  = XBusy;
        end
      end
      XBusy: begin
        if (!ack) begin
          done    = 1'b1;
          state_d = XIdle;
        end
      end
      default: state_d = XIdle;
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state_q <= XIdle;
      write_q <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start && state_q == XIdle) begin
        write_q <= is_write;
        drive_q <= drive;
      end
    end
  end

endmodule

// File: rtl/disk_track_sequencer.sv
// Loads/writes back 13-block track images for two Disk II drives over one SD channel.
// Write-back of modified tracks is built only when DISK_WRITEBACK_EN is defined.
module disk_track_sequencer #(
  parameter int unsigned BLOCKS_PER_TRACK = 13,
  parameter int unsigned LBA_W            = 32
) (
  input  logic             CLK_14M,
  input  logic             RESET,
  input  logic [1:0]       IMG_MOUNTED,
  output logic [1:0]       DISK_READY,
  input  logic [5:0]       TRACK1,
  input  logic [5:0]       TRACK2,
  input  logic             TRACK1_WE,
  input  logic             TRACK2_WE,
  input  logic             D1_ACTIVE,
  input  logic             D2_ACTIVE,
  output logic             TRACK1_BUSY,
  output logic             TRACK2_BUSY,
  output logic [LBA_W-1:0] SD_LBA,
  output logic [1:0]       SD_RD,
  output logic [1:0]       SD_WR,
  input  logic [1:0]       SD_ACK,
  input  logic [8:0]       SD_BUFF_ADDR,
  input  logic             SD_BUFF_WR,
  output logic             RAM_SEL,
  output logic [12:0]      RAM_ADDR,
  output logic             RAM_WE
);
  import disk_ii_pkg::*;

`ifdef DISK_WRITEBACK_EN
  localparam bit WbEn = 1'b1;
`else
  localparam bit WbEn = 1'b0;
`endif

  localparam logic [3:0] LastBlk = 4'(BLOCKS_PER_TRACK - 1);

  logic [1:0][5:0] track;
  logic [1:0]      trk_we;
  logic [1:0]      active;

  logic [1:0][5:0] cur_trk_q;
  logic [1:0]      valid_q, dirty_q, mounted_q, active_q, stop_q, busy_q;
  logic [1:0]      need_load, need_wb, pending, act_fall;

  seq_state_e state_q, state_d;
  logic       own_q, own_d;
  logic       rr_q, rr_d;
  logic [3:0] blk_q, blk_d;
  logic [5:0] load_trk_q, load_trk_d;
  logic       abort_q, abort_now;

  logic xfer_start, xfer_write, ack_seen, xfer_done;
  logic wb_end, fin, abort_end;
  logic wb_phase, rd_phase;
  logic [5:0] lba_trk;

  assign track    = {TRACK2, TRACK1};
  assign trk_we   = {TRACK2_WE, TRACK1_WE};
  assign active   = {D2_ACTIVE, D1_ACTIVE};
  assign act_fall = active_q & ~active;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      need_load[n] = mounted_q[n] & (~valid_q[n] | (cur_trk_q[n] != track[n]));
      need_wb[n]   = WbEn & dirty_q[n] & (need_load[n] | stop_q[n]);
    end
  end
  assign pending = need_load | need_wb;

  assign wb_phase   = (state_q == StWbReq) || (state_q == StWbAck) || (state_q == StWbDone);
  assign rd_phase   = (state_q == StRdReq) || (state_q == StRdAck) || (state_q == StRdDone);
  assign xfer_write = wb_phase;
  // A remount during the owner's transfer may arrive in the very DONE cycle.
  assign abort_now  = abort_q | IMG_MOUNTED[own_q];

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    rr_d       = rr_q;
    blk_d      = blk_q;
    load_trk_d = load_trk_q;
    xfer_start = 1'b0;
    wb_end     = 1'b0;
    fin        = 1'b0;
    abort_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|pending) begin
          own_d      = (pending[0] & pending[1]) ? ~rr_q : pending[1];
          rr_d       = own_d;
          blk_d      = 4'd0;
          load_trk_d = track[own_d];
          state_d    = need_wb[own_d] ? StWbReq : StRdReq;
        end
      end
      StWbReq: begin
        xfer_start = 1'b1;
        state_d    = StWbAck;
      end
      StWbAck: if (ack_seen) state_d = StWbDone;
      StWbDone: begin
        if (xfer_done) begin
          if (abort_now) begin
            abort_end = 1'b1;
            state_d   = StIdle;
          end else if (blk_q == LastBlk) begin
            wb_end  = 1'b1;
            blk_d   = 4'd0;
            state_d = need_load[own_q] ? StRdReq : StIdle;
          end else begin
            blk_d   = blk_q + 4'd1;
            state_d = StWbReq;
          end
        end
      end
      StRdReq: begin
        xfer_start = 1'b1;
        state_d    = StRdAck;
      end
      StRdAck: if (ack_seen) state_d = StRdDone;
      StRdDone: begin
        if (xfer_done) begin
          if (abort_now) begin
            abort_end = 1'b1;
            state_d   = StIdle;
          end else if (blk_q == LastBlk) begin
            state_d = StFin;
          end else begin
            blk_d   = blk_q + 4'd1;
            state_d = StRdReq;
          end
        end
      end
      StFin: begin
        fin     = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state_q    <= StIdle;
      own_q      <= 1'b0;
      rr_q       <= 1'b1;
      blk_q      <= 4'd0;
      load_trk_q <= 6'd0;
      abort_q    <= 1'b0;
      cur_trk_q  <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      mounted_q  <= '0;
      active_q   <= '0;
      stop_q     <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      rr_q       <= rr_d;
      blk_q      <= blk_d;
      load_trk_q <= load_trk_d;
      abort_q    <= (state_q == StIdle) ? 1'b0 : abort_now;
      for (int n = 0; n < 2; n++) begin
        active_q[n] <= active[n];
        busy_q[n]   <= need_load[n] | (state_q != StIdle && own_q == 1'(n));
        // A new image always wins over a transfer finishing in the same cycle.
        if (IMG_MOUNTED[n]) begin
          mounted_q[n] <= 1'b1;
          valid_q[n]   <= 1'b0;
          dirty_q[n]   <= 1'b0;
          stop_q[n]    <= 1'b0;
        end else begin
          if (fin && own_q == 1'(n)) begin
            cur_trk_q[n] <= load_trk_q;
            valid_q[n]   <= 1'b1;
          end
          if ((wb_end || abort_end) && own_q == 1'(n)) begin
            dirty_q[n] <= 1'b0;
            stop_q[n]  <= 1'b0;
            if (abort_end) valid_q[n] <= 1'b0;
          end else begin
            if (WbEn && mounted_q[n] && trk_we[n] && !busy_q[n]) dirty_q[n] <= 1'b1;
            if (active[n])        stop_q[n] <= 1'b0;
            else if (act_fall[n]) stop_q[n] <= 1'b1;
          end
        end
      end
    end
  end

  sd_block_xfer u_xfer (
    .CLK_14M  (CLK_14M),
    .RESET    (RESET),
    .start    (xfer_start),
    .is_write (xfer_write),
    .drive    (own_q),
    .SD_ACK   (SD_ACK),
    .SD_RD    (SD_RD),
    .SD_WR    (SD_WR),
    .ack_seen (ack_seen),
    .done     (xfer_done)
  );

  assign lba_trk     = wb_phase ? cur_trk_q[own_q] : load_trk_q;
  assign SD_LBA      = LBA_W'(lba_of(lba_trk, blk_q, BLOCKS_PER_TRACK));
  assign DISK_READY  = mounted_q;
  assign TRACK1_BUSY = busy_q[0];
  assign TRACK2_BUSY = busy_q[1];
  assign RAM_SEL     = own_q;
  assign RAM_ADDR    = {blk_q, SD_BUFF_ADDR};
  assign RAM_WE      = SD_BUFF_WR & rd_phase & SD_ACK[own_q];

endmodule

// File: tb/tb_disk_track_sequencer.sv
// Scoreboard bench: expected SD requests queued by stimulus, checked by the SD responder.
module tb_disk_track_sequencer;

  logic        CLK_14M = 1'b0;
  logic        RESET;
  logic [1:0]  IMG_MOUNTED;
  logic [1:0]  DISK_READY;
  logic [5:0]  TRACK1, TRACK2;
  logic        TRACK1_WE, TRACK2_WE, D1_ACTIVE, D2_ACTIVE;
  logic        TRACK1_BUSY, TRACK2_BUSY;
  logic [31:0] SD_LBA;
  logic [1:0]  SD_RD, SD_WR, SD_ACK;
  logic [8:0]  SD_BUFF_ADDR;
  logic        SD_BUFF_WR;
  logic        RAM_SEL;
  logic [12:0] RAM_ADDR;
  logic        RAM_WE;

  always #5 CLK_14M = ~CLK_14M;

  disk_track_sequencer dut (
    .CLK_14M      (CLK_14M),
    .RESET        (RESET),
    .IMG_MOUNTED  (IMG_MOUNTED),
    .DISK_READY   (DISK_READY),
    .TRACK1       (TRACK1),
    .TRACK2       (TRACK2),
    .TRACK1_WE    (TRACK1_WE),
    .TRACK2_WE    (TRACK2_WE),
    .D1_ACTIVE    (D1_ACTIVE),
    .D2_ACTIVE    (D2_ACTIVE),
    .TRACK1_BUSY  (TRACK1_BUSY),
    .TRACK2_BUSY  (TRACK2_BUSY),
    .SD_LBA       (SD_LBA),
    .SD_RD        (SD_RD),
    .SD_WR        (SD_WR),
    .SD_ACK       (SD_ACK),
    .SD_BUFF_ADDR (SD_BUFF_ADDR),
    .SD_BUFF_WR   (SD_BUFF_WR),
    .RAM_SEL      (RAM_SEL),
    .RAM_ADDR     (RAM_ADDR),
    .RAM_WE       (RAM_WE)
  );

  typedef struct {
    bit          wr;
    bit          drv;
    int unsigned lba;
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ram_we_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic push_blocks(input bit wr, input bit drv, input int unsigned trk);
    req_t r;
    for (int b = 0; b < 13; b++) begin
      r.wr  = wr;
      r.drv = drv;
      r.lba = trk * 13 + b;
      exp_q.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge CLK_14M);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int stable = 0;
    int cyc    = 0;
    while (stable < 16 && cyc < budget) begin
      @(negedge CLK_14M);
      cyc++;
      if (exp_q.size() == 0 && SD_ACK == 2'b00 && SD_RD == 2'b00 && SD_WR == 2'b00 &&
          !TRACK1_BUSY && !TRACK2_BUSY) stable++;
      else stable = 0;
    end
    check(name, 32'(stable >= 16), 32'd1);
    if (exp_q.size() != 0) begin
      check({name, "_pending_reqs"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  always @(negedge CLK_14M) if (RAM_WE === 1'b1) ram_we_count++;

  // SD card model and scoreboard monitor
  initial begin
    bit          wr, drv;
    int unsigned lba;
    req_t        e;
    SD_ACK       = 2'b00;
    SD_BUFF_ADDR = 9'd0;
    SD_BUFF_WR   = 1'b0;
    forever begin
      @(posedge CLK_14M);
      #1;
      if ((SD_RD | SD_WR) != 2'b00) begin
        wr  = (SD_WR != 2'b00);
        drv = SD_RD[1] | SD_WR[1];
        lba = SD_LBA;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: got wr=%0d drive=%0d lba=%0d required no request",
                   wr, drv, lba);
        end else begin
          e = exp_q.pop_front();
          check("req_dir", 32'(wr), 32'(e.wr));
          check("req_drive", 32'(drv), 32'(e.drv));
          check("req_lba", lba, e.lba);
          check("ram_sel", 32'(RAM_SEL), 32'(e.drv));
          check("busy_in_xfer", 32'(drv ? TRACK2_BUSY : TRACK1_BUSY), 32'd1);
        end
        SD_ACK[drv] = 1'b1;
        if (!wr) begin
          for (int i = 0; i < 512; i++) begin
            SD_BUFF_ADDR = 9'(i);
            SD_BUFF_WR   = 1'b1;
            if (i == 1) check("req_dropped", 32'(SD_RD | SD_WR), 32'd0);
            if (i == 511) begin
              #1;
              check("ram_addr", 32'(RAM_ADDR), 32'({4'(lba % 13), 9'h1FF}));
            end
            @(posedge CLK_14M);
            #1;
          end
          SD_BUFF_WR = 1'b0;
        end else begin
          @(posedge CLK_14M);
          #1;
          check("req_dropped", 32'(SD_RD | SD_WR), 32'd0);
          repeat (3) begin
            @(posedge CLK_14M);
            #1;
          end
        end
        SD_ACK = 2'b00;
      end
    end
  end

  initial begin
    int we0;
    int found;
    RESET       = 1'b1;
    IMG_MOUNTED = 2'b00;
    TRACK1      = 6'd0;
    TRACK2      = 6'd0;
    TRACK1_WE   = 1'b0;
    TRACK2_WE   = 1'b0;
    D1_ACTIVE   = 1'b0;
    D2_ACTIVE   = 1'b0;
    repeat (4) tick();
    @(negedge CLK_14M);
    check("rst_ready", 32'(DISK_READY), 32'd0);
    check("rst_sd_rd", 32'(SD_RD), 32'd0);
    check("rst_sd_wr", 32'(SD_WR), 32'd0);
    check("rst_busy", 32'({TRACK2_BUSY, TRACK1_BUSY}), 32'd0);
    check("rst_lba", SD_LBA, 32'd0);
    check("rst_ram_sel", 32'(RAM_SEL), 32'd0);
    tick();
    RESET = 1'b0;

    // Mount drive 1 on track 0: full load of LBA 0..12
    push_blocks(1'b0, 1'b0, 0);
    we0 = ram_we_count;
    IMG_MOUNTED = 2'b01;
    tick();
    IMG_MOUNTED = 2'b00;
    tick();
    check("t1_busy1_rise", 32'(TRACK1_BUSY), 32'd1);
    wait_idle("t1_done", 20000);
    check("t1_ram_we", 32'(ram_we_count - we0), 32'd6656);
    check("t1_ready", 32'(DISK_READY), 32'd1);
    check("t1_busy1", 32'(TRACK1_BUSY), 32'd0);

    // Modify track 0 then seek to 3
`ifdef DISK_WRITEBACK_EN
    push_blocks(1'b1, 1'b0, 0);
`endif
    push_blocks(1'b0, 1'b0, 3);
    TRACK1_WE = 1'b1;
    tick();
    TRACK1_WE = 1'b0;
    tick();
    TRACK1 = 6'd3;
    wait_idle("t2_done", 30000);

    // Both drives need a load in the same cycle: drive 1 goes first
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    TRACK1 = 6'd2;
    TRACK2 = 6'd5;
    push_blocks(1'b0, 1'b0, 2);
    push_blocks(1'b0, 1'b1, 5);
    IMG_MOUNTED = 2'b11;
    tick();
    IMG_MOUNTED = 2'b00;
    wait_idle("t3_done", 40000);
    check("t3_ready", 32'(DISK_READY), 32'd3);

    // Remount drive 1 while block 5 of a load is in flight
    for (int b = 0; b < 6; b++) exp_q.push_back('{wr: 1'b0, drv: 1'b0, lba: 52 + b});
    push_blocks(1'b0, 1'b0, 4);
    TRACK1 = 6'd4;
    found = 0;
    for (int c = 0; c < 20000 && found == 0; c++) begin
      @(negedge CLK_14M);
      if (SD_RD[0] && SD_LBA == 32'd57) found = 1;
    end
    check("t4_blk5_seen", 32'(found), 32'd1);
    IMG_MOUNTED = 2'b01;
    tick();
    IMG_MOUNTED = 2'b00;
    tick();
    check("t4_busy1_held", 32'(TRACK1_BUSY), 32'd1);
    wait_idle("t4_done", 30000);
    check("t4_busy2", 32'(TRACK2_BUSY), 32'd0);

    // Drive 2 modified, motor stops, track unchanged
`ifdef DISK_WRITEBACK_EN
    push_blocks(1'b1, 1'b1, 5);
`endif
    D2_ACTIVE = 1'b1;
    tick();
    TRACK2_WE = 1'b1;
    tick();
    TRACK2_WE = 1'b0;
    D2_ACTIVE = 1'b0;
    wait_idle("t5_done", 20000);
    check("t5_sd_wr_idle", 32'(SD_WR), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
